// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: M-extension FUNCT3 codes, mul/div FSM states and
// datapath constants.
package riscv_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [2:0] MUL    = 3'd0;
   localparam logic [2:0] MULH   = 3'd1;
   localparam logic [2:0] MULHSU = 3'd2;
   localparam logic [2:0] MULHU  = 3'd3;
   localparam logic [2:0] DIV    = 3'd4;
   localparam logic [2:0] DIVU   = 3'd5;
   localparam logic [2:0] REM    = 3'd6;
   localparam logic [2:0] REMU   = 3'd7;

   localparam logic [XLEN-1:0] INT_MIN  = 32'h8000_0000;
   localparam logic [XLEN-1:0] ALL_ONES = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StFix  = 2'd2,
      StDone = 2'd3
   } md_state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the core and the iterative mul/div unit.
interface muldiv_unit_if;
   import riscv_pkg::*;

   logic            START;
   logic [2:0]      FUNCT3;
   logic [XLEN-1:0] SRC_A;
   logic [XLEN-1:0] SRC_B;
   logic            BUSY;
   logic            DONE;
   logic [XLEN-1:0] RESULT;

   modport master (
      output START, FUNCT3, SRC_A, SRC_B,
      input  BUSY, DONE, RESULT
   );

   modport slave (
      input  START, FUNCT3, SRC_A, SRC_B,
      output BUSY, DONE, RESULT
   );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32-step shift-add / restoring shift-subtract
// on magnitudes, sign fix-up in a final cycle, single-cycle special cases.
module muldiv_unit
   import riscv_pkg::*;
(
   input  logic          CLK,
   input  logic          RST_N,
   muldiv_unit_if.slave  bus
);

   md_state_e       state_q, state_d;
   logic [2:0]      op_q, op_d;
   logic            neg_a_q, neg_a_d;
   logic            neg_b_q, neg_b_d;
   logic [XLEN-1:0] opnd_q, opnd_d;
   logic [63:0]     work_q, work_d;
   logic [4:0]      cnt_q, cnt_d;
   logic [XLEN-1:0] result_q, result_d;

   // Request decode
   logic            sign_a_f, sign_b_f, neg_a_in, neg_b_in;
   logic [XLEN-1:0] mag_a, mag_b;
   logic            div_zero, div_ovf, special;
   logic [XLEN-1:0] special_res;

   always_comb begin
      sign_a_f = (bus.FUNCT3 == MULH) || (bus.FUNCT3 == MULHSU) ||
                 (bus.FUNCT3 == DIV)  || (bus.FUNCT3 == REM);
      sign_b_f = (bus.FUNCT3 == MULH) || (bus.FUNCT3 == DIV) || (bus.FUNCT3 == REM);
      neg_a_in = sign_a_f && bus.SRC_A[XLEN-1];
      neg_b_in = sign_b_f && bus.SRC_B[XLEN-1];
      mag_a    = neg_a_in ? -bus.SRC_A : bus.SRC_A;
      mag_b    = neg_b_in ? -bus.SRC_B : bus.SRC_B;
      div_zero = bus.FUNCT3[2] && (bus.SRC_B == '0);
      div_ovf  = ((bus.FUNCT3 == DIV) || (bus.FUNCT3 == REM)) &&
                 (bus.SRC_A == INT_MIN) && (bus.SRC_B == ALL_ONES);
      special  = div_zero || div_ovf;
      if (div_zero) begin
         special_res = bus.FUNCT3[1] ? bus.SRC_A : ALL_ONES;
      end else begin
         special_res = bus.FUNCT3[1] ? '0 : INT_MIN;
      end
   end

   // Shared 33-bit adder: add multiplicand for MUL, subtract divisor for DIV.
   logic        is_div;
   logic [32:0] add_a, add_b, add_s;
   logic [63:0] step;

   always_comb begin
      is_div = op_q[2];
      add_a  = is_div ? work_q[63:31] : {1'b0, work_q[63:32]};
      if (is_div) begin
         add_b = ~{1'b0, opnd_q};
      end else begin
         add_b = work_q[0] ? {1'b0, opnd_q} : '0;
      end
      add_s = add_a + add_b + {32'b0, is_div};
      if (!is_div) begin
         step = {add_s, work_q[31:1]};
      end else if (add_s[32]) begin
         step = {work_q[62:0], 1'b0};
      end else begin
         step = {add_s[31:0], work_q[30:0], 1'b1};
      end
   end

   // Sign correction and result select
   logic [63:0]     prod;
   logic [XLEN-1:0] quo, rem, fix_res;

   always_comb begin
      prod = (neg_a_q ^ neg_b_q) ? -work_q : work_q;
      quo  = (neg_a_q ^ neg_b_q) ? -work_q[31:0] : work_q[31:0];
      rem  = neg_a_q ? -work_q[63:32] : work_q[63:32];
      unique case (op_q)
         MUL:                 fix_res = prod[31:0];
         MULH, MULHSU, MULHU: fix_res = prod[63:32];
         DIV, DIVU:           fix_res = quo;
         default:             fix_res = rem;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      neg_a_d  = neg_a_q;
      neg_b_d  = neg_b_q;
      opnd_d   = opnd_q;
      work_d   = work_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (bus.START) begin
               op_d    = bus.FUNCT3;
               neg_a_d = neg_a_in;
               neg_b_d = neg_b_in;
               cnt_d   = '0;
               if (special) begin
                  result_d = special_res;
                  state_d  = StDone;
               end else begin
                  // Divide iterates the dividend against the divisor; multiply
                  // shifts the multiplier out while adding the multiplicand.
                  opnd_d  = bus.FUNCT3[2] ? mag_b : mag_a;
                  work_d  = {32'b0, bus.FUNCT3[2] ? mag_a : mag_b};
                  state_d = StRun;
               end
            end else if (state_q == StDone) begin
               state_d = StIdle;
            end
         end
         StRun: begin
            work_d = step;
            cnt_d  = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = StFix;
            end
         end
         StFix: begin
            result_d = fix_res;
            state_d  = StDone;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= StIdle;
         op_q     <= '0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         opnd_q   <= '0;
         work_q   <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         neg_a_q  <= neg_a_d;
         neg_b_q  <= neg_b_d;
         opnd_q   <= opnd_d;
         work_q   <= work_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   assign bus.BUSY   = (state_q == StRun) || (state_q == StFix);
   assign bus.DONE   = (state_q == StDone);
   assign bus.RESULT = result_q;

endmodule
